pc_unit: RTL and testbench



---
 rtl/pc_defs.sv | 26 ++
 rtl/sync2.sv | 27 ++
 rtl/pc_unit.sv | 96 +++++++++
 tb/tb_pc_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_defs.sv
// rtl/pc_defs.sv - shared PC-select encodings and fixed PC vectors
// Purpose: constants shared by the PC unit and the control stage.
//   PCSRC_*   : next-PC select encodings driven by control on PCSrc[2:0]
//   RESET_PC  : PC loaded on reset (kernel entry)
//   ILLOP_VEC : interrupt vector
//   XADR_VEC  : undefined-instruction exception vector
package pc_defs;

  localparam logic [2:0] PCSRC_NEXT   = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_JR     = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP  = 3'd4;
  localparam logic [2:0] PCSRC_XADR   = 3'd5;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  // PC+4 that never changes mode: the add covers bits 30:0 only and the
  // carry out of bit 30 is dropped, bit 31 passes straight through.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous level input
// Purpose: bring an asynchronous single-bit level into the clk domain.
// Ports:
//   clk   in  core clock
//   reset in  asynchronous active-high reset, forces both stages to 0
//   d     in  asynchronous input level
//   q     out synchronized level (two clk edges of latency)
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter, next-PC select and interrupt latch
// Purpose: holds the architectural PC, forms PC+4 and the next PC from the
// control select, and owns the synchronized pending-interrupt latch.
// Ports:
//   reset       in  asynchronous active-high reset
//   clk         in  core clock
//   Stall       in  hold PC and the pending clear this cycle
//   PCSrc       in  [2:0] next-PC select (see pc_defs PCSRC_*)
//   BranchTaken in  branch condition, used only for PCSRC_BRANCH
//   ConBA       in  [31:0] branch target
//   JT          in  [25:0] jump target field
//   DataBusA    in  [31:0] rs value for JR/JALR
//   IRQIn       in  asynchronous level interrupt request
//   PC          out [31:0] current instruction address
//   NewPC       out [31:0] PC+4 with bit 31 preserved
//   IRQ         out interrupt request to control (masked in kernel mode)
//   IRQPending  out latched interrupt status
module pc_unit
  import pc_defs::*;
(
  input  logic        reset,
  input  logic        clk,
  input  logic        Stall,
  input  logic [2:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] DataBusA,
  input  logic        IRQIn,
  output logic [31:0] PC,
  output logic [31:0] NewPC,
  output logic        IRQ,
  output logic        IRQPending
);

  logic [31:0] next_pc;
  logic        irq_sync;
  logic        irq_hist;
  logic        irq_rise;
  logic        irq_clear;

  assign NewPC = pc_plus4(PC);

  always_comb begin
    next_pc = XADR_VEC;
    case (PCSrc)
      PCSRC_NEXT:   next_pc = NewPC;
      PCSRC_BRANCH: next_pc = BranchTaken ? ConBA : NewPC;
      PCSRC_JUMP:   next_pc = {NewPC[31:28], JT, 2'b00};
      // Supervisor bit can only be kept or dropped by JR, never gained.
      PCSRC_JR:     next_pc = {PC[31] & DataBusA[31], DataBusA[30:0]};
      PCSRC_ILLOP:  next_pc = ILLOP_VEC;
      default:      next_pc = XADR_VEC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC <= RESET_PC;
    end else if (!Stall) begin
      PC <= next_pc;
    end
  end

  sync2 u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (IRQIn),
    .q     (irq_sync)
  );

  // A held-high request yields a single event: only the 0->1 transition
  // of the synchronized level sets the latch.
  assign irq_rise  = irq_sync & ~irq_hist;
  assign irq_clear = (PCSrc == PCSRC_ILLOP) && !Stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_hist   <= 1'b0;
      IRQPending <= 1'b0;
    end else begin
      irq_hist <= irq_sync;
      // Set is checked first so a new request arriving on the same edge
      // as the vector being taken is not lost.
      if (irq_rise) begin
        IRQPending <= 1'b1;
      end else if (irq_clear) begin
        IRQPending <= 1'b0;
      end
    end
  end

  // Interrupts stay latched but are not requested while in kernel mode.
  assign IRQ = IRQPending & ~PC[31];

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard testbench for pc_unit
module tb_pc_unit;

  logic        reset;
  logic        clk;
  logic        Stall;
  logic [2:0]  PCSrc;
  logic        BranchTaken;
  logic [31:0] ConBA;
  logic [25:0] JT;
  logic [31:0] DataBusA;
  logic        IRQIn;
  logic [31:0] PC;
  logic [31:0] NewPC;
  logic        IRQ;
  logic        IRQPending;

  pc_unit dut (
    .reset       (reset),
    .clk         (clk),
    .Stall       (Stall),
    .PCSrc       (PCSrc),
    .BranchTaken (BranchTaken),
    .ConBA       (ConBA),
    .JT          (JT),
    .DataBusA    (DataBusA),
    .IRQIn       (IRQIn),
    .PC          (PC),
    .NewPC       (NewPC),
    .IRQ         (IRQ),
    .IRQPending  (IRQPending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] epc,
                               input logic epend);
    logic [31:0] enew;
    enew = {epc[31], epc[30:0] + 31'd4};
    check_value({tag, ".pc"},    PC, epc);
    check_value({tag, ".newpc"}, NewPC, enew);
    check_value({tag, ".pend"},  {31'd0, IRQPending}, {31'd0, epend});
    check_value({tag, ".irq"},   {31'd0, IRQ}, {31'd0, epend & ~epc[31]});
  endtask

  // Drive one cycle of inputs on the falling edge, push the expected
  // post-edge state, then pop and compare just after the rising edge.
  task automatic step(input string tag, input logic [2:0] src,
                      input logic bt, input logic [31:0] cba,
                      input logic [25:0] jt, input logic [31:0] dba,
                      input logic stall, input logic irq_in,
                      input logic [31:0] epc, input logic epend);
    exp_t e;
    exp_t got_e;
    @(negedge clk);
    PCSrc       = src;
    BranchTaken = bt;
    ConBA       = cba;
    JT          = jt;
    DataBusA    = dba;
    Stall       = stall;
    IRQIn       = irq_in;
    e.tag  = tag;
    e.pc   = epc;
    e.pend = epend;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_value({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got_e = exp_q.pop_front();
      check_outputs(got_e.tag, got_e.pc, got_e.pend);
    end
  endtask

  task automatic jr(input string tag, input logic [31:0] dba,
                    input logic [31:0] epc, input logic epend);
    step(tag, 3'd3, 1'b0, 32'd0, 26'd0, dba, 1'b0, 1'b0, epc, epend);
  endtask

  task automatic nxt(input string tag, input logic irq_in,
                     input logic [31:0] epc, input logic epend);
    step(tag, 3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, irq_in, epc, epend);
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; PCSrc = 3'd0; BranchTaken = 1'b0;
    ConBA = 32'd0; JT = 26'd0; DataBusA = 32'd0; IRQIn = 1'b0;
    #1;
    check_outputs("reset_init", 32'h8000_0000, 1'b0);
    #3 reset = 1'b0;

    // Reset mid-run, no clock edge required
    jr("jr_40", 32'h0000_0040, 32'h0000_0040, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_outputs("reset_async", 32'h8000_0000, 1'b0);
    reset = 1'b0;

    // Branch taken / not taken
    jr("jr_100", 32'h0000_0100, 32'h0000_0100, 1'b0);
    step("br_taken", 3'd1, 1'b1, 32'h0000_0200, 26'd0, 32'd0, 1'b0, 1'b0,
         32'h0000_0200, 1'b0);
    jr("jr_100b", 32'h0000_0100, 32'h0000_0100, 1'b0);
    step("br_not", 3'd1, 1'b0, 32'h0000_0200, 26'd0, 32'd0, 1'b0, 1'b0,
         32'h0000_0104, 1'b0);

    // Jump and PC+4 wrap without mode change (reached through kernel)
    step("illop_a", 3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0,
         32'h8000_0004, 1'b0);
    jr("jr_400010", 32'h0040_0010, 32'h0040_0010, 1'b0);
    step("jump", 3'd2, 1'b0, 32'd0, 26'h000_0040, 32'd0, 1'b0, 1'b0,
         32'h0000_0100, 1'b0);
    step("xadr_a", 3'd5, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0,
         32'h8000_0008, 1'b0);
    jr("jr_7ffffffc", 32'h7FFF_FFFC, 32'h7FFF_FFFC, 1'b0);
    nxt("wrap", 1'b0, 32'h0000_0000, 1'b0);

    // JR privilege rules
    jr("jr_20", 32'h0000_0020, 32'h0000_0020, 1'b0);
    jr("jr_user_to_k", 32'h8000_1000, 32'h0000_1000, 1'b0);
    step("illop_b", 3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0,
         32'h8000_0004, 1'b0);
    jr("jr_k_50", 32'h8000_0050, 32'h8000_0050, 1'b0);
    jr("jr_k_to_user", 32'h0000_0300, 32'h0000_0300, 1'b0);

    // Exception vector for 5, 6, 7
    step("src5", 3'd5, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 32'h8000_0008, 1'b0);
    step("src6", 3'd6, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 32'h8000_0008, 1'b0);
    step("src7", 3'd7, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 32'h8000_0008, 1'b0);

    // Interrupt in kernel mode: latched after 3 edges, masked
    nxt("irq_e1", 1'b1, 32'h8000_000C, 1'b0);
    nxt("irq_e2", 1'b1, 32'h8000_0010, 1'b0);
    nxt("irq_e3", 1'b1, 32'h8000_0014, 1'b1);
    nxt("irq_low", 1'b0, 32'h8000_0018, 1'b1);
    jr("irq_to_user", 32'h0000_0500, 32'h0000_0500, 1'b1);
    step("illop_stall", 3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b0,
         32'h0000_0500, 1'b1);
    step("illop_take", 3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0,
         32'h8000_0004, 1'b0);

    // Held-high request gives one event only
    jr("jr_600", 32'h0000_0600, 32'h0000_0600, 1'b0);
    nxt("hold_e1", 1'b1, 32'h0000_0604, 1'b0);
    nxt("hold_e2", 1'b1, 32'h0000_0608, 1'b0);
    nxt("hold_e3", 1'b1, 32'h0000_060C, 1'b1);
    nxt("hold_e4", 1'b1, 32'h0000_0610, 1'b1);
    step("hold_take", 3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b1,
         32'h8000_0004, 1'b0);
    nxt("hold_e6", 1'b1, 32'h8000_0008, 1'b0);
    nxt("hold_e7", 1'b1, 32'h8000_000C, 1'b0);

    // New edge coinciding with the clear: set wins
    nxt("drop_1", 1'b0, 32'h8000_0010, 1'b0);
    nxt("drop_2", 1'b0, 32'h8000_0014, 1'b0);
    nxt("drop_3", 1'b0, 32'h8000_0018, 1'b0);
    nxt("rise_1", 1'b1, 32'h8000_001C, 1'b0);
    nxt("rise_2", 1'b1, 32'h8000_0020, 1'b0);
    step("set_wins", 3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b1,
         32'h8000_0004, 1'b1);

    // Plain stall holds PC
    jr("jr_700", 32'h0000_0700, 32'h0000_0700, 1'b1);
    step("stall_next", 3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1, 1'b1,
         32'h0000_0700, 1'b1);

    if (exp_q.size() != 0) check_value("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
